// File: rtl/clock_div_pkg.sv
// clock_div_pkg
//   Shared types and helpers for the clock_div_multi fractional divider.
//   ch_state_e : per-channel FSM state (IDLE / RUN / DRAIN)
//   MAX_INC    : largest increment for the default 16-bit accumulator (f_clk/2)
//   calc_inc   : rounded increment for f_out from f_src with a given accumulator width
package clock_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  localparam logic [15:0] MAX_INC = 16'h8000;

  function automatic longint unsigned calc_inc(input longint unsigned f_src,
                                               input longint unsigned f_out,
                                               input int unsigned     bits);
    return ((f_out << bits) + (f_src >> 1)) / f_src;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan
//   One phase-accumulator divider channel: accumulator, active/pending increment
//   and IDLE/RUN/DRAIN FSM. All outputs registered.
//   Optional feature macro: CLOCK_DIV_PHASE_SYNC_EN (sync_i clears the phase of
//   running/draining channels; without it sync_i is ignored).
// Ports
//   clk_i   source clock            rst_ni  synchronous active-low reset
//   wr_i    increment write strobe  inc_i   new (already clamped) increment
//   en_i    level enable            sync_i  phase-align strobe
//   run_o   channel in RUN/DRAIN    clk_o   accumulator MSB    tick_o  carry strobe
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int unsigned             ACC_BITS    = 16,
  parameter logic [ACC_BITS-1:0]     DEFAULT_INC = ACC_BITS'(107)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_i,
  input  logic [ACC_BITS-1:0] inc_i,
  input  logic                en_i,
  input  logic                sync_i,
  output logic                run_o,
  output logic                clk_o,
  output logic                tick_o
);

  ch_state_e           state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d, act_q, act_d, pend_q, pend_d;
  logic                pvld_q, pvld_d, clk_q, clk_d, tick_q, tick_d;
  logic [ACC_BITS:0]   sum;
  logic                carry, sync_hit, apply;

  assign sum   = {1'b0, acc_q} + {1'b0, act_q};
  assign carry = sum[ACC_BITS];

`ifdef CLOCK_DIV_PHASE_SYNC_EN
  assign sync_hit = sync_i && (state_q != IDLE);
`else
  logic unused_sync;
  assign unused_sync = sync_i;
  assign sync_hit    = 1'b0;
`endif

  // Pending increment only lands on a period boundary so the running
  // waveform never sees a mid-period rate change.
  assign apply = pvld_q && ((state_q == IDLE) || sync_hit || carry);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN: begin
        if (act_q == '0)            state_d = IDLE;
        else if (carry && !sync_hit) state_d = IDLE;
        else if (en_i)              state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    act_d  = act_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    // Apply reads the old pending value; a same-cycle write refills it and
    // waits for the next boundary.
    if (apply) begin
      act_d  = pend_q;
      pvld_d = 1'b0;
    end
    if (wr_i) begin
      pend_d = inc_i;
      pvld_d = 1'b1;
    end
    unique case (state_q)
      IDLE: acc_d = '0;
      RUN: begin
        acc_d  = sum[ACC_BITS-1:0];
        clk_d  = sum[ACC_BITS-1];
        tick_d = carry;
      end
      DRAIN: begin
        if (act_q == '0) begin
          acc_d = '0;
        end else if (carry) begin
          acc_d  = '0;
          tick_d = 1'b1;
        end else begin
          acc_d = sum[ACC_BITS-1:0];
          clk_d = sum[ACC_BITS-1];
        end
      end
      default: acc_d = '0;
    endcase
    if (sync_hit) begin
      acc_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      act_q  <= DEFAULT_INC;
      pend_q <= DEFAULT_INC;
      pvld_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign run_o  = (state_q != IDLE);
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi
//   N-channel runtime-programmable fractional clock divider on one source clock.
//   f_out = f_clk * inc / 2^ACC_BITS per channel.
//   Optional feature macro: CLOCK_DIV_PHASE_SYNC_EN (phase-align on sync).
// Ports
//   clk, rst_n            source clock, synchronous active-low reset
//   cfg_wr/cfg_ch/cfg_inc increment write strobe, target channel, new increment
//   ch_en                 per-channel level enable
//   sync                  phase-align strobe (ignored unless the macro is defined)
//   ch_run/clk_out/tick   per-channel running flag, square wave, carry strobe
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         ACC_BITS    = 16,
  parameter logic [ACC_BITS-1:0] DEFAULT_INC = ACC_BITS'(107),
  localparam int unsigned        CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_BITS-1:0] cfg_inc,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] ch_run,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [ACC_BITS-1:0] INC_LIMIT = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic [ACC_BITS-1:0] inc_clamped;

  assign inc_clamped = (cfg_inc > INC_LIMIT) ? INC_LIMIT : cfg_inc;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic wr;
    // Out-of-range cfg_ch matches no generated channel, so the write is dropped.
    assign wr = cfg_wr && (cfg_ch == CH_W'(g));

    clock_div_chan #(
      .ACC_BITS    (ACC_BITS),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_chan (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .wr_i   (wr),
      .inc_i  (inc_clamped),
      .en_i   (ch_en[g]),
      .sync_i (sync),
      .run_o  (ch_run[g]),
      .clk_o  (clk_out[g]),
      .tick_o (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
module tb_clock_div_multi;
  import clock_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, cfg_wr, sync;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_inc;
  logic [2:0]  ch_en, ch_run, clk_out, tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_div_multi #(
    .CHANNELS    (3),
    .ACC_BITS    (16),
    .DEFAULT_INC (16'd107)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_inc (cfg_inc),
    .ch_en   (ch_en),
    .sync    (sync),
    .ch_run  (ch_run),
    .clk_out (clk_out),
    .tick    (tick)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [15:0] inc;
    logic        en;
    logic        run;
    logic        co;
    logic        tk;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(input logic wr, input logic [1:0] ch, input logic [15:0] inc,
                              input logic en, input logic run, input logic co, input logic tk);
    vec_t v;
    v.wr = wr; v.ch = ch; v.inc = inc; v.en = en; v.run = run; v.co = co; v.tk = tk;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt, last, bad;
    logic [1:0] en_bits;

    // ch0: idle write applied, run at 16384, drain, drain->run, clamp, bad channel
    tbl[0]  = mk(1, 0, 16'd16384, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 16'd0,     0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 16'd0,     1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 16'd0,     1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[5]  = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[7]  = mk(0, 0, 16'd0,     1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[10] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[11] = mk(0, 0, 16'd0,     0, 1, 0, 0);
    tbl[12] = mk(0, 0, 16'd0,     0, 1, 1, 0);
    tbl[13] = mk(0, 0, 16'd0,     0, 1, 1, 0);
    tbl[14] = mk(0, 0, 16'd0,     0, 0, 0, 1);
    tbl[15] = mk(0, 0, 16'd0,     0, 0, 0, 0);
    tbl[16] = mk(0, 0, 16'd0,     1, 1, 0, 0);
    tbl[17] = mk(0, 0, 16'd0,     0, 1, 0, 0);
    tbl[18] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[19] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[20] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[21] = mk(0, 0, 16'd0,     1, 1, 0, 0);
    tbl[22] = mk(1, 0, 16'hFFFF,  1, 1, 1, 0);
    tbl[23] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[24] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[25] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[26] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[27] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[28] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[29] = mk(1, 3, 16'd100,   1, 1, 1, 0);
    tbl[30] = mk(0, 0, 16'd0,     1, 1, 0, 1);
    tbl[31] = mk(0, 0, 16'd0,     1, 1, 1, 0);
    tbl[32] = mk(0, 0, 16'd0,     1, 1, 0, 1);

    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0; ch_en = '0; sync = 1'b0;
    repeat (3) step;
    chk("reset_run", ch_run, 0);
    chk("reset_clk", clk_out, 0);
    chk("reset_tick", tick, 0);
    rst_n = 1'b1;

    // ch2 at the reset increment over one full accumulator wrap
    ch_en = 3'b100;
    step;
    chk("ch2_run", ch_run[2], 1);
    cnt = 0; last = 0; bad = 0;
    for (int k = 1; k <= 65536; k++) begin
      step;
      if (tick[2]) begin
        cnt++;
        if ((k - last) < 612 || (k - last) > 613) bad++;
        last = k;
      end
    end
    chk("inc107_count", cnt, 32'(calc_inc(27000000, 44100, 16)));
    chk("inc107_gap_bad", bad, 0);
    chk("inc107_last_tick", last, 65536);

    for (int i = 0; i < 33; i++) begin
      cfg_wr = tbl[i].wr; cfg_ch = tbl[i].ch; cfg_inc = tbl[i].inc;
      ch_en = {1'b1, 1'b0, tbl[i].en};
      step;
      chk($sformatf("tbl%0d_run", i), ch_run[0], tbl[i].run);
      chk($sformatf("tbl%0d_clk", i), clk_out[0], tbl[i].co);
      chk($sformatf("tbl%0d_tick", i), tick[0], tbl[i].tk);
    end
    cfg_wr = 1'b0;

    // inc=0 holds phase; draining with inc=0 drops straight to idle
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd0;
    step;
    cfg_wr = 1'b0;
    step;
    chk("inc0_last_tick", tick[0], 1);
    step;
    chk("inc0_hold_tick", tick[0], 0);
    chk("inc0_hold_run", ch_run[0], 1);
    step;
    chk("inc0_hold_clk", clk_out[0], 0);
    ch_en = 3'b100;
    step;
    chk("inc0_drain_run", ch_run[0], 1);
    step;
    chk("inc0_idle_run", ch_run[0], 0);
    chk("inc0_idle_clk", clk_out[0], 0);

    // ch1 rate change at period boundaries, last-write-wins, write on carry
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd16384;
    step;
    cfg_wr = 1'b0;
    step;
    ch_en = 3'b110;
    step;
    for (int k = 1; k <= 40; k++) begin
      cfg_wr  = (k == 6 || k == 7 || k == 24);
      cfg_ch  = 2'd1;
      cfg_inc = (k == 6) ? 16'd4096 : (k == 7) ? 16'd8192 : 16'd16384;
      step;
      chk($sformatf("rate_k%0d_tick", k), tick[1],
          (k == 4 || k == 8 || k == 16 || k == 24 || k == 32 || k == 36 || k == 40));
    end
    cfg_wr = 1'b0;

    // reset while channels run
    rst_n = 1'b0;
    step;
    chk("midrst_run", ch_run, 0);
    chk("midrst_clk", clk_out, 0);
    chk("midrst_tick", tick, 0);
    ch_en = 3'b000;
    step;
    rst_n = 1'b1;

`ifdef CLOCK_DIV_PHASE_SYNC_EN
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd16384;
    step;
    cfg_ch = 2'd1; cfg_inc = 16'd8192;
    step;
    cfg_wr = 1'b0;
    step;
    ch_en = 3'b001;
    repeat (3) step;
    ch_en = 3'b011;
    repeat (3) step;
    sync = 1'b1;
    step;
    sync = 1'b0;
    chk("sync_tick", tick[1:0], 0);
    chk("sync_clk", clk_out[1:0], 0);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("sync_k%0d_tick0", k), tick[0], (k % 4) == 0);
      chk($sformatf("sync_k%0d_tick1", k), tick[1], k == 8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
